// File: rtl/givens_qr_ctrl_if.sv
// Bundles the upstream, downstream and rotation-engine handshakes of the Givens QR sequencer.
// The master side is the sequencer and the slave side is the surrounding datapath and engine.
interface givens_qr_ctrl_if #(
  parameter int N = 8
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic          in_valid;
  logic          in_ready;
  logic          load_en;
  logic          gr_start;
  logic [CW-1:0] gr_col;
  logic          gr_sel_fb;
  logic          gr_done;
  logic          out_valid;
  logic          out_ready;

  modport master (
    input  in_valid, out_ready, gr_done,
    output in_ready, load_en, gr_start, gr_col, gr_sel_fb, out_valid
  );

  modport slave (
    output in_valid, out_ready, gr_done,
    input  in_ready, load_en, gr_start, gr_col, gr_sel_fb, out_valid
  );
endinterface

// File: rtl/givens_qr_ctrl.sv
// Sequences N-1 column-elimination passes of the shared Givens engine for one channel frame,
// with a stall watchdog on each pass and a completed-frame counter.
//
// state  | meaning
// IDLE   | ready for a new frame; load_en follows in_valid
// ISSUE  | one-cycle gr_start for pass k; watchdog cleared
// WAIT   | waiting for gr_done; watchdog counting
// DONE   | result presented downstream until out_ready
module givens_qr_ctrl #(
  parameter int N       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  givens_qr_ctrl_if.master     bus,
  output logic                 busy,
  output logic                 err,
  output logic [15:0]          frame_cnt
);
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [KW-1:0] K_LAST = KW'(N - 2);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state;
  logic [KW-1:0] k;
  logic [TW-1:0] tmo_cnt;

  assign bus.in_ready = (state == S_IDLE);
  assign bus.load_en  = bus.in_valid && (state == S_IDLE);
  assign busy         = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      k             <= '0;
      tmo_cnt       <= '0;
      err           <= 1'b0;
      frame_cnt     <= '0;
      bus.gr_start  <= 1'b0;
      bus.gr_col    <= '0;
      bus.gr_sel_fb <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.gr_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            k             <= '0;
            err           <= 1'b0;
            bus.gr_start  <= 1'b1;
            bus.gr_col    <= '0;
            bus.gr_sel_fb <= 1'b0;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmo_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          // a done pulse arriving on the last watchdog cycle still completes the pass
          if (bus.gr_done) begin
            if (k == K_LAST) begin
              bus.out_valid <= 1'b1;
              state         <= S_DONE;
            end else begin
              k             <= k + 1'b1;
              bus.gr_start  <= 1'b1;
              bus.gr_col    <= k + 1'b1;
              bus.gr_sel_fb <= 1'b1;
              state         <= S_ISSUE;
            end
          end else if (tmo_cnt == T_LAST) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            frame_cnt     <= frame_cnt + 16'd1;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
